// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared constants for the multiply/divide unit: instruction
//               decode values, func3 operation encodings and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Instruction decode values that select the multiply/divide unit
    localparam logic [6:0] c_OPCODE_OP    = 7'b0110011;
    localparam logic [6:0] c_FUNC7_MULDIV = 7'b0000001;

    // func3 operation encodings
    localparam logic [2:0] c_F3_MUL    = 3'b000;
    localparam logic [2:0] c_F3_MULH   = 3'b001;
    localparam logic [2:0] c_F3_MULHSU = 3'b010;
    localparam logic [2:0] c_F3_MULHU  = 3'b011;
    localparam logic [2:0] c_F3_DIV    = 3'b100;
    localparam logic [2:0] c_F3_DIVU   = 3'b101;
    localparam logic [2:0] c_F3_REM    = 3'b110;
    localparam logic [2:0] c_F3_REMU   = 3'b111;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative integer multiply/divide unit. Multiplies by XLEN
//               shift-add steps and divides by XLEN restoring steps, both on
//               operand magnitudes, then applies sign correction in FIX.
//               Divide-by-zero and signed overflow complete in one edge.
// Ports       : clk, rst (async, active-high)
//               start, instruction_opcode, func7, func3, rs1, rs2 - request
//               busy   - operation in progress, new starts ignored
//               done   - one-cycle completion pulse
//               result - last completed result, held until next completion
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [6:0]      instruction_opcode,
    input  logic [6:0]      func7,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              c_CW        = $clog2(XLEN) + 1;
    localparam logic [c_CW-1:0] c_LAST_ITER = c_CW'(XLEN - 1);
    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);
    localparam logic [XLEN-1:0] c_MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [2:0]        r_func3;
    logic              r_neg_q;   // negate product / quotient in FIX
    logic              r_neg_r;   // negate remainder in FIX
    logic [XLEN-1:0]   r_hi;      // product high half / partial remainder
    logic [XLEN-1:0]   r_lo;      // multiplier -> product low half / dividend -> quotient
    logic [XLEN-1:0]   r_opb;     // multiplicand / divisor magnitude

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic            w_can_accept;
    logic            w_accept;
    logic            w_is_div;
    logic            w_rs1_signed;
    logic            w_rs2_signed;
    logic            w_rs1_neg;
    logic            w_rs2_neg;
    logic [XLEN-1:0] w_rs1_mag;
    logic [XLEN-1:0] w_rs2_mag;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;

    // Acceptance looks at the state directly rather than at busy so the
    // FSM output block and the accept decode do not form a false loop.
    assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept     = start && w_can_accept
                       && (instruction_opcode == c_OPCODE_OP)
                       && (func7 == c_FUNC7_MULDIV);

    assign w_is_div     = func3[2];
    assign w_rs1_signed = (func3 == c_F3_MULH) || (func3 == c_F3_MULHSU)
                       || (func3 == c_F3_DIV)  || (func3 == c_F3_REM);
    assign w_rs2_signed = (func3 == c_F3_MULH) || (func3 == c_F3_DIV)
                       || (func3 == c_F3_REM);
    assign w_rs1_neg    = w_rs1_signed && rs1[XLEN-1];
    assign w_rs2_neg    = w_rs2_signed && rs2[XLEN-1];
    // The most negative value maps onto 2^(XLEN-1), which still fits unsigned.
    assign w_rs1_mag    = w_rs1_neg ? -rs1 : rs1;
    assign w_rs2_mag    = w_rs2_neg ? -rs2 : rs2;

    assign w_div_zero   = w_is_div && (rs2 == '0);
    assign w_div_ovf    = ((func3 == c_F3_DIV) || (func3 == c_F3_REM))
                       && (rs1 == c_MIN_NEG) && (rs2 == '1);
    assign w_special    = w_div_zero || w_div_ovf;

    // func3[1] distinguishes remainder forms from quotient forms.
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = func3[1] ? rs1 : '1;
        end else if (w_div_ovf) begin
            w_special_res = func3[1] ? '0 : rs1;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (r_cnt == c_LAST_ITER) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                busy        = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (w_accept) begin
                    w_state_nxt = w_special ? ST_DONE : ST_CALC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Iteration step (one shift-add or one restoring-divide step)
    // ------------------------------------------------------------------
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_shift;
    logic [XLEN:0]   w_div_diff;
    logic [XLEN-1:0] w_hi_step;
    logic [XLEN-1:0] w_lo_step;

    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
        w_div_shift = {r_hi, r_lo[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        w_hi_step   = r_hi;
        w_lo_step   = r_lo;
        if (r_func3[2]) begin
            // Partial remainder stays below the divisor, so the dropped top
            // bit is always zero on whichever path is kept.
            if (!w_div_diff[XLEN]) begin
                w_hi_step = w_div_diff[XLEN-1:0];
                w_lo_step = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_hi_step = w_div_shift[XLEN-1:0];
                w_lo_step = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            // {r_hi, r_lo} shifts right one bit; carry enters r_hi's MSB.
            w_hi_step = w_mul_sum[XLEN:1];
            w_lo_step = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Sign correction and result selection (used in FIX)
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_res;

    always_comb begin
        w_prod_fix = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
        w_quo_fix  = r_neg_q ? -r_lo : r_lo;
        w_rem_fix  = r_neg_r ? -r_hi : r_hi;
        case (r_func3)
            c_F3_MUL:               w_fix_res = w_prod_fix[XLEN-1:0];
            c_F3_DIV,  c_F3_DIVU:   w_fix_res = w_quo_fix;
            c_F3_REM,  c_F3_REMU:   w_fix_res = w_rem_fix;
            default:                w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_func3 <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opb   <= '0;
            result  <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= '0;
                r_func3 <= func3;
                r_neg_q <= w_rs1_neg ^ w_rs2_neg;
                r_neg_r <= w_rs1_neg;
                r_hi    <= '0;
                r_lo    <= w_rs1_mag;
                r_opb   <= w_rs2_mag;
                if (w_special) begin
                    result <= w_special_res;
                end
            end else if (r_state == ST_CALC) begin
                r_cnt <= r_cnt + c_ONE;
                r_hi  <= w_hi_step;
                r_lo  <= w_lo_step;
            end else if (r_state == ST_FIX) begin
                result <= w_fix_res;
            end
        end
    end

endmodule
`default_nettype wire
